uart_loopback_fifo: RTL
=======================

UART_LOOPBACK_FIFO -- requirements
Module: uart_loopback_fifo

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH, 8, byte width; DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries; TERMINATOR, 8'h0D, line-mode release byte (DATA_WIDTH bits).
REQ-002 clock_i  input  1  sole clock, all state on rising edge.
REQ-003 reset_i  input  1  asynchronous, active-high reset.
REQ-004 rx_data_i  input  DATA_WIDTH  received byte from UartRx data_o.
REQ-005 rx_ready_i  input  1  UartRx ready_o.
REQ-006 rx_clear_ready_o  output  1  to UartRx clear_ready_i.
REQ-007 tx_data_o  output  DATA_WIDTH  to UartTx data_i.
REQ-008 tx_write_o  output  1  to UartTx write_i, one-cycle pulse.
REQ-009 tx_busy_i  input  1  UartTx busy_o.
REQ-010 line_mode_i  input  1  0 = stream echo, 1 = release only complete lines.
REQ-011 clear_overflow_i  input  1  clears overflow_o.
REQ-012 count_o  output  DEPTH_LOG2+1  current FIFO occupancy, 0..DEPTH.
REQ-013 empty_o, full_o, overflow_o  output  1 each  count_o==0, count_o==DEPTH, sticky drop flag.

Function
REQ-014 Rx FSM states RX_IDLE, RX_ACK; RX_IDLE with rx_ready_i=1 -> capture rx_data_i, rx_clear_ready_o=1 that cycle, go RX_ACK.
REQ-015 Capture pushes the byte if full_o=0 (pre-cycle count); if full_o=1 the byte is dropped and overflow_o set next edge.
REQ-016 RX_ACK holds rx_clear_ready_o=1 until rx_ready_i=0, then RX_IDLE; exactly one push/drop per ready assertion.
REQ-017 Tx FSM states TX_IDLE, TX_WAIT_BUSY, TX_WAIT_DONE.
REQ-018 TX_IDLE: if release condition true and tx_busy_i=0 -> pop head into registered tx_data_o, tx_write_o=1 next cycle for exactly one cycle, go TX_WAIT_BUSY.
REQ-019 TX_WAIT_BUSY -> TX_WAIT_DONE when tx_busy_i=1; TX_WAIT_DONE -> TX_IDLE when tx_busy_i=0; no pop outside TX_IDLE.
REQ-020 tx_data_o stable from its tx_write_o pulse until the next pop.
REQ-021 Release condition: line_mode_i=0 -> count_o>0; line_mode_i=1 -> term_count>0 or full_o=1.
REQ-022 term_count (internal, DEPTH_LOG2+1 bits) = number of TERMINATOR bytes stored; +1 on push of TERMINATOR, -1 on pop of TERMINATOR, net change on simultaneous push and pop.
REQ-023 line_mode_i change takes effect the next cycle; 1->0 with bytes stored releases them immediately, in order.
REQ-024 Simultaneous push and pop: count_o unchanged, both pointers advance; pop on empty never occurs.
REQ-025 Pointers DEPTH_LOG2 bits, wrap modulo DEPTH; byte order preserved across wrap.
REQ-026 overflow_o sticky until clear_overflow_i=1; set and clear same cycle -> set wins.
REQ-027 count_o, empty_o, full_o registered, consistent with pointers every cycle.

Reset
REQ-028 reset_i=1 asynchronously forces RX_IDLE, TX_IDLE, pointers/count_o/term_count=0, empty_o=1, full_o=0, overflow_o=0, rx_clear_ready_o=0, tx_write_o=0, tx_data_o=0.
REQ-029 Reset mid-transfer discards FIFO contents; release effective on first clock edge after deassertion.
REQ-030 FIFO storage array needs no reset.

Verification
REQ-031 line_mode_i=0, Rx bytes 8'h41, 8'h42 -> tx_write_o pulses twice, tx_data_o 8'h41 then 8'h42, each after prior tx_busy_i falls.
REQ-032 line_mode_i=1, bytes 8'h61, 8'h62 -> no tx_write_o; then 8'h0D -> three writes 8'h61, 8'h62, 8'h0D, count_o returns 0.
REQ-033 DEPTH=16, tx_busy_i held 1, 17 bytes received -> count_o=16, full_o=1, overflow_o=1, 17th byte absent from output; clear_overflow_i -> overflow_o=0.
REQ-034 line_mode_i=1, 16 non-terminator bytes -> full release, all 16 emitted in order.
REQ-035 40 bytes streamed with concurrent push/pop -> output sequence equals input, pointer wrap verified, count_o never exceeds 16.
REQ-036 reset_i pulsed mid-line with count_o=5 -> all outputs at reset values asynchronously, no further tx_write_o until new data.

Source files
------------

// File: rtl/uart_loopback_fifo.sv
// rtl/uart_loopback_fifo.sv - UART echo buffer with stream or line-release modes
module uart_loopback_fifo #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH_LOG2 = 4,
  parameter logic [DATA_WIDTH-1:0] TERMINATOR = DATA_WIDTH'(8'h0D)
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  rx_ready_i,
  output logic                  rx_clear_ready_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_write_o,
  input  logic                  tx_busy_i,
  input  logic                  line_mode_i,
  input  logic                  clear_overflow_i,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  overflow_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic {RX_IDLE, RX_ACK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_t;

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         term_count;
  logic [CW-1:0]         count_next;
  logic                  flushing;

  logic rx_capture;
  logic push, drop, pop;
  logic push_term, pop_term;
  logic release_ok;

  // Rx handshake: capture on ready, hold clear_ready until UartRx drops ready
  always_comb begin
    rx_next          = rx_state;
    rx_clear_ready_o = 1'b0;
    rx_capture       = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_ready_i) begin
          rx_capture       = 1'b1;
          rx_clear_ready_o = 1'b1;
          rx_next          = RX_ACK;
        end
      end
      RX_ACK: begin
        rx_clear_ready_o = 1'b1;
        if (!rx_ready_i) rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  assign push      = rx_capture && !full_o;
  assign drop      = rx_capture && full_o;
  assign push_term = push && (rx_data_i == TERMINATOR);
  assign pop_term  = pop && (mem[rd_ptr] == TERMINATOR);

  // A full buffer with no terminator is an overlong line; once it fills it is
  // drained completely rather than one byte at a time
  assign release_ok = line_mode_i ? ((term_count != '0) || full_o || flushing)
                                  : !empty_o;

  // Tx sequencing: pop only when idle, then follow UartTx busy up and down
  always_comb begin
    tx_next = tx_state;
    pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (release_ok && !tx_busy_i && !empty_o) begin
          pop     = 1'b1;
          tx_next = TX_WAIT_BUSY;
        end
      end
      TX_WAIT_BUSY: if (tx_busy_i)  tx_next = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!tx_busy_i) tx_next = TX_IDLE;
      default:      tx_next = TX_IDLE;
    endcase
  end

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_next = count_o;
    case ({push, pop})
      2'b10:   count_next = count_o + CW'(1);
      2'b01:   count_next = count_o - CW'(1);
      default: count_next = count_o;
    endcase
  end

  // FSM state registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rx_state <= RX_IDLE;
      tx_state <= TX_IDLE;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
    end
  end

  // Storage array; contents are meaningless outside the pointer window
  always_ff @(posedge clock_i) begin
    if (push) mem[wr_ptr] <= rx_data_i;
  end

  // Pointers, occupancy flags, terminator tally and flush latch
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      empty_o    <= 1'b1;
      full_o     <= 1'b0;
      term_count <= '0;
      flushing   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      count_o <= count_next;
      empty_o <= (count_next == '0);
      full_o  <= (count_next == CW'(DEPTH));
      case ({push_term, pop_term})
        2'b10:   term_count <= term_count + CW'(1);
        2'b01:   term_count <= term_count - CW'(1);
        default: term_count <= term_count;
      endcase
      flushing <= (flushing || (line_mode_i && full_o)) && (count_next != '0);
    end
  end

  // Tx output register: data latched on pop, write strobe one cycle later
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      tx_data_o  <= '0;
      tx_write_o <= 1'b0;
    end else begin
      tx_write_o <= pop;
      if (pop) tx_data_o <= mem[rd_ptr];
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      overflow_o <= 1'b0;
    end else if (drop) begin
      overflow_o <= 1'b1;
    end else if (clear_overflow_i) begin
      overflow_o <= 1'b0;
    end
  end

endmodule
